branch_predict_pc_unit: RTL and testbench
=========================================

// Module: branch_predict_pc_unit
// PURPOSE
//  Fetch-stage PC sequencer: owns the PC register and predicts branches with a direct-mapped
//  table of 2-bit counters plus stored targets (BHT/BTB). Resolves B/BR in decode, checks the
//  resolution against the carried prediction, redirects fetch and raises a one-cycle flush on
//  mispredict. Parametrised successor of the decode-stage next-PC logic.
// PARAMETERS
//  PC_W      16      PC / target / register-data width
//  IMM_W     9       B-type immediate width, signed, in halfwords
//  ENTRIES   16      BHT/BTB entries, power of 2, >=2; index = pc[log2(ENTRIES):1]
//  RESET_PC  0       PC value loaded at reset
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  stall          in   1       hold fetch PC (hazard); ignored while redirect is asserted
//  fetch_pc       out  PC_W    PC of the instruction being fetched
//  pred_taken     out  1       prediction for fetch_pc; carried down the pipe
//  pred_target    out  PC_W    predicted target for fetch_pc; carried down the pipe
//  dec_valid      in   1       decode slot holds a real instruction
//  dec_opcode     in   4       1100 = B (PC-relative), 1101 = BR (register); other = non-branch
//  dec_cond       in   3       branch condition code
//  dec_imm        in   IMM_W   signed halfword offset for B
//  dec_reg_data   in   PC_W    target register value for BR
//  dec_pc         in   PC_W    PC of the decode instruction
//  dec_pred_taken in   1       pred_taken carried with the decode instruction
//  dec_pred_tgt   in   PC_W    pred_target carried with the decode instruction
//  flags          in   3       {Z,V,N}
//  branch_taken   out  1       decode branch resolved taken (combinational)
//  flush          out  1       registered; squash fetch/decode for one cycle
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC; flush=0; all counters=2'b01 (weakly not-taken); all target
//   valid bits=0. Outputs are driven from reset state immediately (async reset).
//  Prediction (combinational from fetch_pc): pred_taken = cnt[idx][1] & valid[idx];
//   pred_target = tgt[idx]. No tag check; aliasing is caught by decode resolution.
//  Condition (taken): 000 ~Z | 001 Z | 010 ~Z&~N | 011 N | 100 Z|(~Z&~N) | 101 Z|N |
//   110 V | 111 always. is_br = dec_valid & (opcode==1100 | opcode==1101).
//  branch_taken = is_br & cond_true.
//  Target: B = dec_pc + 2 + (sign_extend(dec_imm) << 1); BR = dec_reg_data. Mod 2^PC_W.
//  redirect = dec_valid & (
//   (is_br & branch_taken & (~dec_pred_taken | dec_pred_tgt != target)) |
//   (is_br & ~branch_taken & dec_pred_taken) |
//   (~is_br & dec_pred_taken)).
//  Next fetch_pc priority: redirect -> (branch_taken ? target : dec_pc+2);
//   else stall -> hold; else pred_taken -> pred_target; else fetch_pc+2.
//  flush <= redirect (asserted exactly the cycle after the mispredicted branch is in decode).
//  Table update on the clock edge where is_br, indexed by dec_pc: counter saturating +1 if
//   taken, -1 if not (11 and 00 saturate). If taken: tgt<=target, valid<=1.
//   Non-branch with dec_pred_taken: clear valid at that index. Stall does not block updates.
//  Decode inputs are ignored while flush=1 (the slot is squashed).
//  Same-index fetch read and decode write in one cycle: read returns old contents.
//  Reset mid-operation: everything returns to reset values asynchronously; no pending redirect.
// TESTING
//  1 Reset, no branches, stall=0: fetch_pc 0,2,4,6...; pred_taken=0; flush never asserts.
//  2 B at pc 0x0010, imm=+4, cond=111, cold table: branch_taken=1, redirect -> fetch_pc 0x001A
//    next cycle, flush=1 one cycle; counter 01->10, tgt=0x001A valid.
//  3 Same branch refetched: pred_taken=1, pred_target=0x001A, next fetch_pc 0x001A, no flush;
//    counter 10->11, then repeat: stays 11.
//  4 Trained branch, Z=0 with cond=001: not taken, flush=1, fetch_pc -> 0x0012; counter 11->10.
//  5 BR with predicted target 0x0040 but dec_reg_data=0x0080: flush, fetch_pc -> 0x0080,
//    tgt updated to 0x0080. Negative imm=0x1FF at pc 0x0020 -> target 0x0020.
//  6 stall=1 with no redirect: fetch_pc holds; stall=1 with redirect: redirect wins. Assert
//    rst_n low mid-redirect: fetch_pc=RESET_PC, flush=0 at once.

Source files
------------

// File: rtl/branch_predict_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_pc_unit
// Description : Fetch-stage PC sequencer with a direct-mapped BHT/BTB
//               (2-bit counters plus targets). Resolves B/BR in decode,
//               redirects fetch and raises a one-cycle flush on mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_pc_unit #(
    parameter int unsigned         PC_W     = 16,
    parameter int unsigned         IMM_W    = 9,
    parameter int unsigned         ENTRIES  = 16,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              dec_valid,
    input  logic [3:0]        dec_opcode,
    input  logic [2:0]        dec_cond,
    input  logic [IMM_W-1:0]  dec_imm,
    input  logic [PC_W-1:0]   dec_reg_data,
    input  logic [PC_W-1:0]   dec_pc,
    input  logic              dec_pred_taken,
    input  logic [PC_W-1:0]   dec_pred_tgt,
    input  logic [2:0]        flags,
    output logic              branch_taken,
    output logic              flush
);

    localparam int unsigned     IDX_W    = $clog2(ENTRIES);
    localparam logic [3:0]      c_op_b   = 4'b1100;
    localparam logic [3:0]      c_op_br  = 4'b1101;
    localparam logic [PC_W-1:0] c_pc_inc = PC_W'(2);

    logic [1:0]      r_cnt   [ENTRIES];
    logic [PC_W-1:0] r_tgt   [ENTRIES];
    logic            r_valid [ENTRIES];
    logic [PC_W-1:0] r_fetch_pc;
    logic            r_flush;

    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_dec_idx;
    logic             w_dv;
    logic             w_is_br;
    logic             w_cond_true;
    logic             w_z;
    logic             w_v;
    logic             w_n;
    logic [PC_W-1:0]  w_imm_ext;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_dec_seq;
    logic             w_redirect;
    logic             w_clr;
    logic [1:0]       w_cnt_next;
    logic [PC_W-1:0]  w_next_pc;

    // Table indices skip bit 0 since instructions are halfword aligned
    assign w_fetch_idx = r_fetch_pc[IDX_W:1];
    assign w_dec_idx   = dec_pc[IDX_W:1];

    // Prediction reads old table contents, so a same-cycle write is not visible
    assign pred_taken  = r_cnt[w_fetch_idx][1] & r_valid[w_fetch_idx];
    assign pred_target = r_tgt[w_fetch_idx];
    assign fetch_pc    = r_fetch_pc;
    assign flush       = r_flush;

    // The decode slot is squashed during flush, so its contents are masked off
    assign w_dv    = dec_valid & ~r_flush;
    assign w_is_br = w_dv & ((dec_opcode == c_op_b) | (dec_opcode == c_op_br));

    assign w_z = flags[2];
    assign w_v = flags[1];
    assign w_n = flags[0];

    // Branch condition decode
    always_comb begin
        w_cond_true = 1'b0;
        case (dec_cond)
            3'b000:  w_cond_true = ~w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = ~w_z & ~w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z | (~w_z & ~w_n);
            3'b101:  w_cond_true = w_z | w_n;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    assign branch_taken = w_is_br & w_cond_true;

    assign w_imm_ext = {{(PC_W-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
    assign w_dec_seq = dec_pc + c_pc_inc;
    assign w_target  = (dec_opcode == c_op_br) ? dec_reg_data
                                               : (w_dec_seq + (w_imm_ext << 1));

    assign w_redirect = w_dv & (
        (w_is_br & branch_taken & (~dec_pred_taken | (dec_pred_tgt != w_target))) |
        (w_is_br & ~branch_taken & dec_pred_taken) |
        (~w_is_br & dec_pred_taken));

    // A non-branch that was predicted taken has aliased onto a stale target
    assign w_clr = w_dv & ~w_is_br & dec_pred_taken;

    // Saturating counter step for the entry addressed by the decode PC
    always_comb begin
        w_cnt_next = r_cnt[w_dec_idx];
        if (branch_taken) begin
            if (r_cnt[w_dec_idx] != 2'b11) begin
                w_cnt_next = r_cnt[w_dec_idx] + 2'd1;
            end
        end else begin
            if (r_cnt[w_dec_idx] != 2'b00) begin
                w_cnt_next = r_cnt[w_dec_idx] - 2'd1;
            end
        end
    end

    // Next fetch PC: redirect beats stall, stall beats prediction
    always_comb begin
        w_next_pc = r_fetch_pc + c_pc_inc;
        if (w_redirect) begin
            w_next_pc = branch_taken ? w_target : w_dec_seq;
        end else if (stall) begin
            w_next_pc = r_fetch_pc;
        end else if (pred_taken) begin
            w_next_pc = pred_target;
        end
    end

    // PC and flush registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_flush    <= 1'b0;
        end else begin
            r_fetch_pc <= w_next_pc;
            r_flush    <= w_redirect;
        end
    end

    // BHT/BTB update from the decode-stage resolution; stall does not block it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i]   <= 2'b01;
                r_tgt[i]   <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (w_is_br) begin
            r_cnt[w_dec_idx] <= w_cnt_next;
            if (branch_taken) begin
                r_tgt[w_dec_idx]   <= w_target;
                r_valid[w_dec_idx] <= 1'b1;
            end
        end else if (w_clr) begin
            r_valid[w_dec_idx] <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_pc_unit
// Description : Directed table-driven bench for branch_predict_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] fetch_pc;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        dec_valid = 1'b0;
    logic [3:0]  dec_opcode = '0;
    logic [2:0]  dec_cond = '0;
    logic [8:0]  dec_imm = '0;
    logic [15:0] dec_reg_data = '0;
    logic [15:0] dec_pc = '0;
    logic        dec_pred_taken = 1'b0;
    logic [15:0] dec_pred_tgt = '0;
    logic [2:0]  flags = '0;
    logic        branch_taken;
    logic        flush;

    int n_cmp = 0;
    int n_fail = 0;

    branch_predict_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_cond(dec_cond),
        .dec_imm(dec_imm), .dec_reg_data(dec_reg_data), .dec_pc(dec_pc),
        .dec_pred_taken(dec_pred_taken), .dec_pred_tgt(dec_pred_tgt),
        .flags(flags), .branch_taken(branch_taken), .flush(flush)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic        st;
        logic        dv;
        logic [3:0]  op;
        logic [2:0]  cond;
        logic [8:0]  imm;
        logic [15:0] rd;
        logic [15:0] dpc;
        logic        dpt;
        logic [15:0] dptgt;
        logic [2:0]  fl;
        logic [15:0] e_pc;
        logic        e_pt;
        logic [15:0] e_ptgt;
        logic        e_bt;
        logic        e_flush;
    } vec_t;

    typedef struct {
        logic        dv;
        logic [3:0]  op;
        logic [2:0]  cond;
        logic [2:0]  fl;
        logic        e_bt;
    } cvec_t;

    vec_t  vecs [$];
    cvec_t cvecs [$];

    function automatic vec_t mk(input logic st, input logic dv, input logic [3:0] op,
                                input logic [2:0] cond, input logic [8:0] imm,
                                input logic [15:0] rd, input logic [15:0] dpc,
                                input logic dpt, input logic [15:0] dptgt,
                                input logic [2:0] fl, input logic [15:0] e_pc,
                                input logic e_pt, input logic [15:0] e_ptgt,
                                input logic e_bt, input logic e_flush);
        vec_t v;
        v.st = st; v.dv = dv; v.op = op; v.cond = cond; v.imm = imm; v.rd = rd;
        v.dpc = dpc; v.dpt = dpt; v.dptgt = dptgt; v.fl = fl; v.e_pc = e_pc;
        v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_bt = e_bt; v.e_flush = e_flush;
        return v;
    endfunction

    function automatic vec_t idle(input logic st, input logic [15:0] e_pc, input logic e_pt,
                                  input logic [15:0] e_ptgt, input logic e_flush);
        return mk(st, 1'b0, 4'h0, 3'd0, 9'h0, 16'h0, 16'h0, 1'b0, 16'h0, 3'b000,
                  e_pc, e_pt, e_ptgt, 1'b0, e_flush);
    endfunction

    function automatic cvec_t mc(input logic dv, input logic [3:0] op, input logic [2:0] cond,
                                 input logic [2:0] fl, input logic e_bt);
        cvec_t c;
        c.dv = dv; c.op = op; c.cond = cond; c.fl = fl; c.e_bt = e_bt;
        return c;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.st; dec_valid = v.dv; dec_opcode = v.op; dec_cond = v.cond;
        dec_imm = v.imm; dec_reg_data = v.rd; dec_pc = v.dpc;
        dec_pred_taken = v.dpt; dec_pred_tgt = v.dptgt; flags = v.fl;
    endtask

    initial begin
        // Sequential vectors: one per clock, expected values are pre-edge outputs
        //           st dv op    cd imm     rd       dpc      dpt dptgt    fl      e_pc     pt ptgt     bt fl
        vecs.push_back(idle(0, 16'h0000, 0, 16'h0, 0));
        vecs.push_back(idle(0, 16'h0002, 0, 16'h0, 0));
        vecs.push_back(idle(0, 16'h0004, 0, 16'h0, 0));
        vecs.push_back(idle(1, 16'h0006, 0, 16'h0, 0));
        vecs.push_back(idle(0, 16'h0006, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 4'hC, 3'd7, 9'h004, 16'h0, 16'h0010, 0, 16'h0, 3'b000, 16'h0008, 0, 16'h0, 1, 0));
        vecs.push_back(mk(0, 1, 4'hC, 3'd7, 9'h004, 16'h0, 16'h0010, 0, 16'h0, 3'b000, 16'h001A, 0, 16'h0, 0, 1));
        vecs.push_back(idle(0, 16'h001C, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 4'hD, 3'd7, 9'h000, 16'h0010, 16'h0002, 0, 16'h0, 3'b000, 16'h001E, 0, 16'h0, 1, 0));
        vecs.push_back(idle(0, 16'h0010, 1, 16'h001A, 1));
        vecs.push_back(mk(0, 1, 4'hC, 3'd7, 9'h004, 16'h0, 16'h0010, 1, 16'h001A, 3'b000, 16'h001A, 0, 16'h0, 1, 0));
        vecs.push_back(mk(0, 1, 4'hC, 3'd7, 9'h004, 16'h0, 16'h0010, 1, 16'h001A, 3'b000, 16'h001C, 0, 16'h0, 1, 0));
        vecs.push_back(mk(0, 1, 4'hC, 3'd1, 9'h004, 16'h0, 16'h0010, 1, 16'h001A, 3'b000, 16'h001E, 0, 16'h0, 0, 0));
        vecs.push_back(idle(0, 16'h0012, 0, 16'h0, 1));
        vecs.push_back(mk(0, 1, 4'hC, 3'd1, 9'h004, 16'h0, 16'h0010, 1, 16'h001A, 3'b000, 16'h0014, 0, 16'h0, 0, 0));
        vecs.push_back(idle(0, 16'h0012, 0, 16'h0, 1));
        vecs.push_back(mk(0, 1, 4'hD, 3'd7, 9'h000, 16'h0080, 16'h0004, 1, 16'h0040, 3'b000, 16'h0014, 0, 16'h0, 1, 0));
        vecs.push_back(idle(0, 16'h0080, 0, 16'h0, 1));
        vecs.push_back(mk(0, 1, 4'hC, 3'd7, 9'h1FF, 16'h0, 16'h0020, 0, 16'h0, 3'b000, 16'h0082, 1, 16'h0010, 1, 0));
        vecs.push_back(idle(0, 16'h0020, 1, 16'h0020, 1));
        vecs.push_back(mk(1, 1, 4'h0, 3'd0, 9'h000, 16'h0, 16'h0004, 1, 16'h0080, 3'b000, 16'h0020, 1, 16'h0020, 0, 0));
        vecs.push_back(idle(0, 16'h0006, 0, 16'h0, 1));
        vecs.push_back(mk(0, 1, 4'hD, 3'd7, 9'h000, 16'h0084, 16'h000A, 0, 16'h0, 3'b000, 16'h0008, 0, 16'h0, 1, 0));
        vecs.push_back(idle(0, 16'h0084, 0, 16'h0, 1));
        vecs.push_back(mk(0, 1, 4'hD, 3'd7, 9'h000, 16'h0010, 16'h000C, 0, 16'h0, 3'b000, 16'h0086, 0, 16'h0, 1, 0));
        vecs.push_back(idle(0, 16'h0010, 0, 16'h0, 1));
        vecs.push_back(idle(0, 16'h0012, 0, 16'h0, 0));

        // Condition-code vectors, flags = {Z,V,N}
        cvecs.push_back(mc(1, 4'hC, 3'd0, 3'b000, 1));
        cvecs.push_back(mc(1, 4'hC, 3'd0, 3'b100, 0));
        cvecs.push_back(mc(1, 4'hC, 3'd1, 3'b100, 1));
        cvecs.push_back(mc(1, 4'hC, 3'd1, 3'b000, 0));
        cvecs.push_back(mc(1, 4'hC, 3'd2, 3'b000, 1));
        cvecs.push_back(mc(1, 4'hC, 3'd2, 3'b001, 0));
        cvecs.push_back(mc(1, 4'hD, 3'd3, 3'b001, 1));
        cvecs.push_back(mc(1, 4'hD, 3'd3, 3'b000, 0));
        cvecs.push_back(mc(1, 4'hC, 3'd4, 3'b001, 0));
        cvecs.push_back(mc(1, 4'hC, 3'd4, 3'b000, 1));
        cvecs.push_back(mc(1, 4'hC, 3'd4, 3'b101, 1));
        cvecs.push_back(mc(1, 4'hC, 3'd5, 3'b000, 0));
        cvecs.push_back(mc(1, 4'hC, 3'd5, 3'b001, 1));
        cvecs.push_back(mc(1, 4'hD, 3'd6, 3'b010, 1));
        cvecs.push_back(mc(1, 4'hC, 3'd6, 3'b101, 0));
        cvecs.push_back(mc(1, 4'hC, 3'd7, 3'b000, 1));
        cvecs.push_back(mc(1, 4'h0, 3'd7, 3'b000, 0));
        cvecs.push_back(mc(1, 4'hE, 3'd7, 3'b000, 0));
        cvecs.push_back(mc(0, 4'hC, 3'd7, 3'b000, 0));

        // Reset state, visible while rst_n is held low
        #10;
        chk("reset fetch_pc", fetch_pc, 16'h0000);
        chk("reset flush", {15'h0, flush}, 16'h0);
        chk("reset pred_taken", {15'h0, pred_taken}, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d fetch_pc", i), fetch_pc, vecs[i].e_pc);
            chk($sformatf("v%0d pred_taken", i), {15'h0, pred_taken}, {15'h0, vecs[i].e_pt});
            if (vecs[i].e_pt)
                chk($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d branch_taken", i), {15'h0, branch_taken}, {15'h0, vecs[i].e_bt});
            chk($sformatf("v%0d flush", i), {15'h0, flush}, {15'h0, vecs[i].e_flush});
            @(posedge clk); #1;
        end

        // Condition codes checked combinationally within one half cycle
        drive(idle(0, 16'h0, 0, 16'h0, 0));
        foreach (cvecs[i]) begin
            dec_valid = cvecs[i].dv; dec_opcode = cvecs[i].op;
            dec_cond = cvecs[i].cond; flags = cvecs[i].fl;
            #2;
            chk($sformatf("cond%0d branch_taken", i), {15'h0, branch_taken}, {15'h0, cvecs[i].e_bt});
        end
        dec_valid = 1'b0;
        flags = 3'b000;
        @(posedge clk); #1;

        // Asynchronous reset while a redirect/flush is in progress
        drive(mk(0, 1, 4'hD, 3'd7, 9'h000, 16'h0050, 16'h000A, 0, 16'h0, 3'b000, 16'h0, 0, 16'h0, 0, 0));
        @(posedge clk); #1;
        drive(idle(0, 16'h0, 0, 16'h0, 0));
        chk("redir fetch_pc", fetch_pc, 16'h0050);
        chk("redir flush", {15'h0, flush}, 16'h1);
        rst_n = 1'b0;
        #1;
        chk("async rst fetch_pc", fetch_pc, 16'h0000);
        chk("async rst flush", {15'h0, flush}, 16'h0);
        chk("async rst pred_taken", {15'h0, pred_taken}, 16'h0);
        @(posedge clk); #1;
        chk("held rst fetch_pc", fetch_pc, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst fetch_pc", fetch_pc, 16'h0002);
        chk("post rst flush", {15'h0, flush}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
